weight_loader: RTL and testbench

Write-side front end for the per-column weight FIFOs that feed the systolic array. It accepts a row-major stream of weights through a valid/ready handshake and distributes it round-robin across `SYS_COLS` FIFO write ports, so that column `c` receives exactly `W_ROWS` words in row order. It throttles on per-FIFO full flags and signals completion of each matrix load. It sits between the weight source (DMA / memory reader) and the FIFO write ports (`wr_en`, `din`, `full`) of the weight buffer.

---
 rtl/weight_loader.sv | 98 +++++++++
 tb/tb_weight_loader.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/weight_loader.sv
// Spreads a row-major weight stream round-robin over SYS_COLS column FIFOs; 1-cycle accept-to-write latency.
// Stalls the whole stream while the current column's FIFO is full; abort/rst return to IDLE.
module weight_loader #(
  parameter int SYS_COLS   = 4,
  parameter int W_BITWIDTH = 8,
  parameter int W_ROWS     = 4
) (
  input  logic                           i_clk,
  input  logic                           i_rst,
  input  logic                           i_start,
  input  logic                           i_abort,
  input  logic                           i_in_valid,
  output logic                           o_in_ready,
  input  logic [W_BITWIDTH-1:0]          i_in_data,
  input  logic [SYS_COLS-1:0]            i_fifo_full,
  output logic [SYS_COLS-1:0]            o_fifo_wr_en,
  output logic [SYS_COLS*W_BITWIDTH-1:0] o_fifo_din,
  output logic                           o_busy,
  output logic                           o_done
);

  localparam int CW = $clog2(SYS_COLS);
  localparam int RW = (W_ROWS > 1) ? $clog2(W_ROWS) : 1;

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_DONE} state_t;

  state_t                         r_state;
  state_t                         w_next;
  logic [CW-1:0]                  r_col;
  logic [RW-1:0]                  r_row;
  logic [SYS_COLS-1:0]            r_wr_en;
  logic [SYS_COLS*W_BITWIDTH-1:0] r_din;
  logic                           w_ready;
  logic                           w_accept;
  logic                           w_last_col;
  logic                           w_last_row;

  assign w_last_col = (r_col == CW'(SYS_COLS - 1));
  assign w_last_row = (r_row == RW'(W_ROWS - 1));
  assign w_accept   = w_ready && i_in_valid;

  always_comb begin
    w_next   = r_state;
    w_ready  = 1'b0;
    o_busy   = 1'b0;
    o_done   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (i_start) w_next = S_LOAD;
      end
      S_LOAD: begin
        o_busy  = 1'b1;
        w_ready = !i_abort && !i_fifo_full[r_col];
        if (i_abort) w_next = S_IDLE;
        else if (w_ready && i_in_valid && w_last_col && w_last_row) w_next = S_DONE;
      end
      S_DONE: begin
        o_busy = 1'b1;
        // abort landing on the final cycle suppresses the completion pulse
        o_done = !i_abort;
        w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  assign o_in_ready   = w_ready;
  assign o_fifo_wr_en = r_wr_en;
  assign o_fifo_din   = r_din;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= S_IDLE;
      r_col   <= '0;
      r_row   <= '0;
      r_wr_en <= '0;
      r_din   <= '0;
    end else begin
      r_state <= w_next;
      r_wr_en <= '0;
      if (r_state == S_IDLE && i_start) begin
        r_col <= '0;
        r_row <= '0;
      end
      if (w_accept) begin
        r_wr_en <= SYS_COLS'(1) << r_col;
        r_din[r_col*W_BITWIDTH +: W_BITWIDTH] <= i_in_data;
        if (w_last_col) begin
          r_col <= '0;
          r_row <= r_row + RW'(1);
        end else begin
          r_col <= r_col + CW'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_weight_loader.sv
// Randomised and directed loads of weight_loader, checked by a queue scoreboard against a word-index model.
module tb_weight_loader;
  localparam int C = 4;
  localparam int W = 8;
  localparam int R = 4;
  localparam int N = C * R;

  logic           clk = 1'b0;
  logic           rst, start, abort, in_valid, in_ready, busy, done;
  logic [W-1:0]   in_data;
  logic [C-1:0]   full, wr_en;
  logic [C*W-1:0] din;

  always #5 clk = ~clk;

  weight_loader #(.SYS_COLS(C), .W_BITWIDTH(W), .W_ROWS(R)) dut (
    .i_clk(clk), .i_rst(rst), .i_start(start), .i_abort(abort),
    .i_in_valid(in_valid), .o_in_ready(in_ready), .i_in_data(in_data),
    .i_fifo_full(full), .o_fifo_wr_en(wr_en), .o_fifo_din(din),
    .o_busy(busy), .o_done(done)
  );

  typedef struct {
    int         col;
    logic [W-1:0] data;
    bit         last;
  } exp_t;

  exp_t         q[$];
  int           n_checks = 0, n_fail = 0, cyc = 0;
  int           k = 0, exp_done = 0, seen_done = 0, t0 = 0, t_done = 0;
  bit           loading = 0, finishing = 0, post_rst = 0;
  logic [W-1:0] lanes[C];

  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [C*W-1:0] packed_lanes();
    logic [C*W-1:0] v;
    for (int c = 0; c < C; c++) v[c*W +: W] = lanes[c];
    return v;
  endfunction

  // Monitor: every write strobe must match the oldest accepted word.
  initial begin
    exp_t e;
    for (int c = 0; c < C; c++) lanes[c] = '0;
    forever begin
      @(negedge clk);
      #2;
      if (wr_en != '0) begin
        if (q.size() == 0) begin
          check("unexpected_write", wr_en, '0);
        end else begin
          e = q.pop_front();
          check("wr_col", wr_en, 64'(C'(1) << e.col));
          check("wr_data", din[e.col*W +: W], e.data);
          check("done_on_last", done, e.last);
          lanes[e.col] = e.data;
          check("din_lanes", din, packed_lanes());
        end
      end else begin
        check("done_without_write", done, 1'b0);
      end
      if (done) begin
        seen_done++;
        t_done = cyc;
      end
      if (rst) for (int c = 0; c < C; c++) lanes[c] = '0;
    end
  end

  // Model in terms of word index k: word k goes to column k%C, row k/C.
  task automatic step(input bit v, input logic [W-1:0] d, input logic [C-1:0] f,
                      input bit st, input bit ab, input bit rs);
    bit er, acc;
    @(negedge clk);
    in_valid = v; in_data = d; full = f; start = st; abort = ab; rst = rs;
    #1;
    if (post_rst) begin
      check("rst_wr_en", wr_en, '0);
      check("rst_din", din, '0);
      check("rst_done", done, 1'b0);
      post_rst = 0;
    end
    er = loading && !ab && !f[k % C];
    check("in_ready", in_ready, er);
    check("busy", busy, loading || finishing);
    acc = v && er && !rs;
    if (acc) begin
      if (k == 0) t0 = cyc;
      q.push_back('{col: k % C, data: d, last: (k == N - 1)});
    end
    if (rs) begin
      loading = 0; finishing = 0; k = 0; post_rst = 1;
    end else if (finishing) begin
      finishing = 0;
    end else if (loading) begin
      if (ab) loading = 0;
      else if (acc) begin
        k++;
        if (k == N) begin
          loading = 0; finishing = 1; exp_done++;
        end
      end
    end else if (st) begin
      loading = 1; k = 0;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, '0, '0, 0, 0, 0);
  endtask

  // mode: 0 nominal, 1 full[2] stall, 2 bubbles, 3 spurious start,
  //       4 random, 5 abort after 6 accepts, 6 rst with the 6th accept
  task automatic run_load(input int mode);
    int           guard = 0, stall = 0;
    bit           tog = 0, stalled = 0, v, st, ab, rs;
    logic [W-1:0] d;
    logic [C-1:0] f;
    step(0, '0, '0, 1, 0, 0);
    while ((loading || finishing) && guard < 200) begin
      v = 1; f = '0; d = W'(k + 1); st = 0; ab = 0; rs = 0;
      case (mode)
        1: if (loading && k % C == 2 && !stalled) begin
             f[2] = 1'b1;
             stall++;
             if (stall == 5) stalled = 1;
           end
        2: begin v = tog; tog = !tog; end
        3: st = (k == 7);
        4: begin
             v = ($urandom_range(0, 3) != 0);
             f = ($urandom_range(0, 3) == 0) ? C'($urandom) : '0;
             d = W'($urandom);
           end
        5: ab = (k == 6);
        6: rs = (k == 5);
        default: ;
      endcase
      step(v, d, f, st, ab, rs);
      guard++;
    end
    check("load_terminates", 64'(loading), 64'(0));
  endtask

  initial begin
    rst = 1; start = 0; abort = 0; in_valid = 0; in_data = '0; full = '0;
    step(0, '0, '0, 0, 0, 1);
    step(0, '0, '0, 0, 0, 1);
    idle(2);

    run_load(0);
    idle(3);
    // done lands N cycles after the first accept: N+1 cycles inclusive
    check("done_latency", t_done - t0, N);

    run_load(1); idle(3);
    run_load(2); idle(3);
    run_load(3); idle(3);
    run_load(5); idle(2);
    run_load(0); idle(3);
    run_load(6); idle(2);
    run_load(0); idle(3);
    for (int i = 0; i < 3; i++) begin
      run_load(4);
      idle(2);
    end
    idle(3);

    check("queue_empty", q.size(), 0);
    check("done_count", seen_done, exp_done);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
